mul_share_arb: RTL and testbench

//  Shares one pipelined 8x8 multiplier (fixed latency, one issue per cycle) among NREQ requesters.

---
 rtl/mul_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/mul_share_arb.sv | 120 ++++++++++++
 tb/tb_mul_share_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared constants and the tag-pipe entry type for the shared-multiplier arbiter.
// The tag field is sized for the largest supported requester count.
package mul_arb_pkg;

  localparam int DEF_SIZE    = 8;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_MUL_LAT = 4;
  localparam int MAX_NREQ    = 8;
  localparam int TAG_W       = $clog2(MAX_NREQ);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr, plus the ptr register.
// The pointer moves to one past the winner and holds when nothing is granted.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] grant_o,
  output logic [TW-1:0]   grant_idx_o,
  output logic            grant_vld_o
);

  logic [TW-1:0] ptr_q, ptr_d, cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = '0;
    ptr_d       = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = TW'((int'(ptr_q) + k) % NREQ);
      if (!grant_vld_o && req_i[cand]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = grant_vld_o && (int'(grant_idx_o) == i);
    end
    if (grant_vld_o) begin
      ptr_d = (grant_idx_o == TW'(NREQ - 1)) ? '0 : grant_idx_o + TW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters; a tag pipe
// aligned to the multiplier latency steers each product back and checks the result strobe.
module mul_share_arb
  import mul_arb_pkg::*;
#(
  parameter int size    = DEF_SIZE,
  parameter int NREQ    = DEF_NREQ,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*size-1:0] req_a,
  input  logic [NREQ*size-1:0] req_b,
  input  logic                 issue_hold,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [2*size-1:0]    rsp_data,
  output logic                 mul_en_in,
  output logic [size-1:0]      mul_a,
  output logic [size-1:0]      mul_b,
  input  logic                 mul_en_out,
  input  logic [2*size-1:0]    mul_out,
  output logic                 busy,
  output logic                 err_orphan,
  output logic                 err_lost
);

  localparam int TW = $clog2(NREQ);

  logic [NREQ-1:0]   eligible, grant;
  logic [TW-1:0]     grant_idx;
  logic              grant_vld;
  logic [size-1:0]   sel_a, sel_b;
  logic [size-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  tag_entry_t        issue_q, issue_d, head;
  tag_entry_t        pipe_q [MUL_LAT];
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [2*size-1:0] rsp_data_q, rsp_data_d;
  logic              err_orphan_q, err_lost_q;
  logic              deliver, busy_c;

  assign eligible = req_valid & {NREQ{~issue_hold & ~rst}};

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req_i       (eligible),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign req_ready = grant;
  assign sel_a     = size'(req_a >> (int'(grant_idx) * size));
  assign sel_b     = size'(req_b >> (int'(grant_idx) * size));

  always_comb begin
    issue_d = '0;
    mul_a_d = '0;
    mul_b_d = '0;
    if (grant_vld) begin
      issue_d.valid = 1'b1;
      issue_d.tag   = TAG_W'(grant_idx);
      mul_a_d       = sel_a;
      mul_b_d       = sel_b;
    end
  end

  // The head entry lines up with the cycle the multiplier should raise mul_en_out.
  assign head    = pipe_q[MUL_LAT-1];
  assign deliver = head.valid & mul_en_out;

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = deliver ? mul_out : '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid_d[i] = deliver && (int'(head.tag) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q      <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
      err_lost_q   <= 1'b0;
      // NOTE: the tag pipe is cleared entry by entry; its valid bits gate delivery, so nothing stale may survive rst.
      for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= '0;
    end else begin
      issue_q      <= issue_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_orphan_q <= err_orphan_q | (mul_en_out & ~head.valid);
      err_lost_q   <= err_lost_q | (head.valid & ~mul_en_out);
      pipe_q[0]    <= issue_q;
      for (int k = 1; k < MUL_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_comb begin
    busy_c = issue_q.valid | (|rsp_valid_q);
    for (int k = 0; k < MUL_LAT; k++) busy_c = busy_c | pipe_q[k].valid;
  end

  assign mul_en_in  = issue_q.valid;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_c;
  assign err_orphan = err_orphan_q;
  assign err_lost   = err_lost_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: behavioural multiplier with fault injection, a transaction-level
// model checked every cycle on the falling edge, and directed scenarios with literal expectations.
module tb_mul_share_arb;

  localparam int SIZE = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int W    = NREQ * SIZE;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [W-1:0]      req_a, req_b;
  logic              issue_hold;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*SIZE-1:0] rsp_data;
  logic              mul_en_in, mul_en_out;
  logic [SIZE-1:0]   mul_a, mul_b;
  logic [2*SIZE-1:0] mul_out;
  logic              busy, err_orphan, err_lost;

  mul_share_arb #(.size(SIZE), .NREQ(NREQ), .MUL_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .issue_hold (issue_hold),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mul_en_in  (mul_en_in),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en_out (mul_en_out),
    .mul_out    (mul_out),
    .busy       (busy),
    .err_orphan (err_orphan),
    .err_lost   (err_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: LAT register stages, optional suppression of one strobe, forced orphan.
  logic              st_en  [LAT];
  logic              st_sup [LAT];
  logic [2*SIZE-1:0] st_p   [LAT];
  int                iss_cnt    = 0;
  int                sup_target = -1;
  logic              force_orph;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        st_en[k]  <= 1'b0;
        st_sup[k] <= 1'b0;
        st_p[k]   <= '0;
      end
    end else begin
      st_en[0]  <= mul_en_in;
      st_sup[0] <= mul_en_in && (iss_cnt == sup_target);
      st_p[0]   <= {8'b0, mul_a} * {8'b0, mul_b};
      for (int k = 1; k < LAT; k++) begin
        st_en[k]  <= st_en[k-1];
        st_sup[k] <= st_sup[k-1];
        st_p[k]   <= st_p[k-1];
      end
      if (mul_en_in) iss_cnt <= iss_cnt + 1;
    end
  end

  assign mul_en_out = force_orph | (st_en[LAT-1] & ~st_sup[LAT-1]);
  assign mul_out    = force_orph ? 16'hBEEF : st_p[LAT-1];

  logic [NREQ-1:0] acc_q;
  bit              drop_mode;
  always @(posedge clk) acc_q <= req_valid & req_ready;

  // Transaction model: issues keyed by accept edge, deliveries keyed by due cycle.
  typedef struct { int e0; int tag; int a; int b; } iss_t;
  typedef struct { int due; int tag; int data; } dlv_t;
  iss_t iq[$];
  iss_t iq_keep[$];
  dlv_t dq[$];
  dlv_t dq_keep[$];
  int   m_ptr = 0;
  bit   m_orph = 0;
  bit   m_lost = 0;

  always @(negedge clk) begin : model
    int              t, gidx, idx, hk, ea, eb;
    logic            exp_en, exp_busy;
    logic [NREQ-1:0] exp_rv, exp_gnt;
    logic [63:0]     exp_rd;
    t = cyc;
    if (t >= 1) begin
      exp_en = 1'b0; ea = 0; eb = 0; exp_busy = 1'b0;
      exp_rv = '0; exp_rd = '0;
      foreach (iq[k]) begin
        if (iq[k].e0 == t) begin exp_en = 1'b1; ea = iq[k].a; eb = iq[k].b; end
        if (t - iq[k].e0 >= 0 && t - iq[k].e0 <= LAT) exp_busy = 1'b1;
      end
      foreach (dq[k]) begin
        if (dq[k].due == t) begin
          exp_rv   = NREQ'(1) << dq[k].tag;
          exp_rd   = 64'(dq[k].data);
          exp_busy = 1'b1;
        end
      end
      check("mul_en_in", mul_en_in, exp_en);
      check("mul_a", mul_a, ea);
      check("mul_b", mul_b, eb);
      check("rsp_valid", rsp_valid, exp_rv);
      check("rsp_data", rsp_data, exp_rd);
      check("busy", busy, exp_busy);
      check("err_orphan", err_orphan, m_orph);
      check("err_lost", err_lost, m_lost);
    end
    gidx = -1;
    exp_gnt = '0;
    if (!rst && !issue_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (gidx < 0 && (((req_valid >> idx) & 1) != 0)) gidx = idx;
      end
    end
    if (gidx >= 0) exp_gnt = NREQ'(1) << gidx;
    if (t >= 1) check("req_ready", req_ready, exp_gnt);
    if (rst) begin
      iq = {}; dq = {}; m_ptr = 0; m_orph = 0; m_lost = 0;
    end else begin
      hk = -1;
      foreach (iq[k]) if (iq[k].e0 == t - LAT) hk = k;
      if (hk >= 0) begin
        if (mul_en_out) dq.push_back('{t + 1, iq[hk].tag, iq[hk].a * iq[hk].b});
        else m_lost = 1;
      end else if (mul_en_out) begin
        m_orph = 1;
      end
      iq_keep = {};
      foreach (iq[k]) if (iq[k].e0 > t - LAT) iq_keep.push_back(iq[k]);
      iq = iq_keep;
      dq_keep = {};
      foreach (dq[k]) if (dq[k].due > t) dq_keep.push_back(dq[k]);
      dq = dq_keep;
      if (gidx >= 0) begin
        iq.push_back('{t + 1, gidx, int'(SIZE'(req_a >> (gidx * SIZE))), int'(SIZE'(req_b >> (gidx * SIZE)))});
        m_ptr = (gidx + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (drop_mode) req_valid = req_valid & ~acc_q;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    logic [W-1:0] m;
    m     = W'({SIZE{1'b1}}) << (i * SIZE);
    req_a = (req_a & ~m) | (W'(a & 255) << (i * SIZE));
    req_b = (req_b & ~m) | (W'(b & 255) << (i * SIZE));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int n, bubbles;
    int exp_d[4];
    bit found;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; issue_hold = 1'b0;
    force_orph = 1'b0; drop_mode = 1'b1;
    step(); step();
    rst = 1'b0;

    // 1: single request
    set_op(0, 3, 5);
    req_valid = 4'b0001;
    step();
    check("t1_en_in", mul_en_in, 1);
    check("t1_mul_a", mul_a, 3);
    check("t1_mul_b", mul_b, 5);
    repeat (4) step();
    check("t1_rsp_early", rsp_valid, 0);
    step();
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rsp_data", rsp_data, 15);
    step();
    check("t1_busy_after", busy, 0);

    // 2: all four at once, held until granted
    pulse_reset();
    set_op(0, 255, 255); set_op(1, 16, 16); set_op(2, 0, 200); set_op(3, 7, 9);
    req_valid = 4'b1111;
    exp_d = '{65025, 256, 0, 63};
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      if (rsp_valid != 0) begin
        check("t2_rsp_onehot", rsp_valid, NREQ'(1) << n);
        check("t2_rsp_data", rsp_data, exp_d[n]);
        n++;
      end
    end
    check("t2_rsp_count", n, 4);

    // 3: requesters 1 and 2 stream continuously
    pulse_reset();
    drop_mode = 1'b0;
    set_op(1, 10, 20); set_op(2, 200, 3);
    req_valid = 4'b0110;
    #1;
    check("t3_grant_1", req_ready, 4'b0010);
    step();
    check("t3_grant_2", req_ready, 4'b0100);
    step();
    check("t3_grant_1b", req_ready, 4'b0010);
    repeat (4) step();

    // 4: three-cycle issue_hold mid-stream
    issue_hold = 1'b1;
    #1;
    check("t4_ready_held", req_ready, 0);
    bubbles = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (!mul_en_in) bubbles++;
      if (c == 2) issue_hold = 1'b0;
    end
    check("t4_bubbles", bubbles, 3);
    req_valid = '0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (!busy) found = 1;
    end
    check("t4_busy_drains", found, 1);

    // 5: reset with work in flight
    drop_mode = 1'b1;
    set_op(0, 11, 12); set_op(1, 13, 14); set_op(2, 15, 16);
    req_valid = 4'b0111;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 1, 2); set_op(1, 3, 4); set_op(2, 5, 6); set_op(3, 8, 8);
    req_valid = 4'b1111;
    #1;
    check("t5_ptr_zero", req_ready, 4'b0001);
    repeat (14) step();
    check("t5_busy", busy, 0);
    check("t5_orphan", err_orphan, 0);
    check("t5_lost", err_lost, 0);

    // 6: orphan strobe, then one suppressed strobe
    force_orph = 1'b1;
    step();
    check("t6_orphan_set", err_orphan, 1);
    check("t6_orphan_norsp", rsp_valid, 0);
    force_orph = 1'b0;
    step();
    sup_target = iss_cnt + 1;
    set_op(0, 2, 3); set_op(1, 4, 5); set_op(2, 6, 7);
    req_valid = 4'b0111;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (rsp_valid != 0) n++;
    end
    check("t6_rsp_count", n, 2);
    check("t6_lost_set", err_lost, 1);
    check("t6_orphan_sticky", err_orphan, 1);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
